// File: rtl/seq10010_tx.sv
// Bit-serial frame transmitter: preamble 1,0,0,1,0 then MSB-first payload, with
// bit stuffing and an idle gap so a 10010 detector fires once per frame.
module seq10010_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             j,
  output logic             busy,
  output logic             stuff,
  output logic             frame_done
);

  localparam int CW = ($clog2(WIDTH + 1) > 3) ? $clog2(WIDTH + 1) : 3;
  localparam int GW = $clog2(GAP);
  localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH);
  localparam logic [CW-1:0] PRE_LAST  = CW'(4);
  localparam logic [GW-1:0] GAP_MAX   = GW'(GAP - 1);
  localparam logic [3:0]    TRIGGER   = 4'b1001;

  typedef enum logic [1:0] {IDLE, PRE, DATA, TAIL} state_t;

  state_t           state, state_n;
  logic [3:0]       h;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    cnt, cnt_n, consumed;
  logic [GW-1:0]    gap_cnt, gap_n;
  logic             j_n, stuff_n, done_n, emit;

  assign busy      = (state != IDLE);
  assign din_ready = (state == IDLE) && (gap_cnt == GAP_MAX);

  // State describes the bit currently on j; h always includes that bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      h          <= '0;
      sreg       <= '0;
      cnt        <= '0;
      gap_cnt    <= GAP_MAX;
      j          <= 1'b0;
      stuff      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      h          <= {h[2:0], j_n};
      sreg       <= sreg_n;
      cnt        <= cnt_n;
      gap_cnt    <= gap_n;
      j          <= j_n;
      stuff      <= stuff_n;
      frame_done <= done_n;
    end
  end

  // In PRE, cnt indexes the preamble bit on the line; in DATA it counts consumed payload bits.
  always_comb begin
    state_n  = state;
    sreg_n   = sreg;
    cnt_n    = cnt;
    gap_n    = gap_cnt;
    j_n      = 1'b0;
    stuff_n  = 1'b0;
    done_n   = 1'b0;
    emit     = 1'b0;
    consumed = cnt;

    unique case (state)
      IDLE: begin
        if (din_valid && din_ready) begin
          state_n = PRE;
          j_n     = 1'b1;
          cnt_n   = '0;
          sreg_n  = din;
        end else if (gap_cnt != GAP_MAX) begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      PRE: begin
        if (cnt != PRE_LAST) begin
          j_n   = (cnt == CW'(2));
          cnt_n = cnt + 1'b1;
        end else begin
          state_n  = DATA;
          consumed = '0;
          emit     = 1'b1;
        end
      end
      DATA: emit = 1'b1;
      TAIL: begin
        state_n = IDLE;
        gap_n   = '0;
      end
      default: state_n = IDLE;
    endcase

    // A stuffed 1 breaks any 1001 history; it also forms the TAIL after the payload.
    if (emit) begin
      if (h == TRIGGER) begin
        j_n     = 1'b1;
        stuff_n = 1'b1;
        cnt_n   = consumed;
        state_n = (consumed == DATA_LAST) ? TAIL : DATA;
        done_n  = (consumed == DATA_LAST);
      end else if (consumed == DATA_LAST) begin
        state_n = IDLE;
        gap_n   = '0;
      end else begin
        state_n = DATA;
        j_n     = sreg[WIDTH-1];
        sreg_n  = sreg << 1;
        cnt_n   = consumed + 1'b1;
        done_n  = (consumed == DATA_LAST - 1'b1) && ({h[2:0], sreg[WIDTH-1]} != TRIGGER);
      end
    end
  end

endmodule

// File: tb/tb_seq10010_tx.sv
// Self-checking bench for seq10010_tx: frame-level reference model, golden 10010
// detector, destuffing receiver, and directed literal frames.
module tb_seq10010_tx;

  localparam int GAP = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready, j, busy, stuff, frame_done;

  typedef struct packed {
    logic j;
    logic stuff;
    logic done;
    logic pre5;
  } bit_t;

  bit_t       q[$];
  bit_t       cur;
  logic       cur_idle = 1'b1;
  int         idle_run = GAP - 1;
  logic       exp_ready = 1'b1;
  logic [7:0] sent_q[$];
  int         rx_pos = 0;
  logic [7:0] rx_word = '0;
  logic [3:0] dhist = '0;
  int         det_count = 0;
  int         pre5_count = 0;
  int         checks = 0;
  int         errors = 0;

  seq10010_tx #(.WIDTH(8), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .j(j), .busy(busy), .stuff(stuff), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame built straight from the rules: preamble, then a 1 whenever the last four line bits are 1001.
  task automatic build_frame(input logic [7:0] w);
    logic b[$];
    logic s[$];
    bit_t e;
    int   k;
    int   n;
    k = 7;
    b.push_back(1'b1); b.push_back(1'b0); b.push_back(1'b0); b.push_back(1'b1); b.push_back(1'b0);
    for (int i = 0; i < 5; i++) s.push_back(1'b0);
    while (k >= 0) begin
      n = b.size();
      if ({b[n-4], b[n-3], b[n-2], b[n-1]} == 4'b1001) begin
        b.push_back(1'b1); s.push_back(1'b1);
      end else begin
        b.push_back(w[k]); s.push_back(1'b0); k--;
      end
    end
    n = b.size();
    if ({b[n-4], b[n-3], b[n-2], b[n-1]} == 4'b1001) begin
      b.push_back(1'b1); s.push_back(1'b1);
    end
    for (int i = 0; i < b.size(); i++) begin
      e.j = b[i];
      e.stuff = s[i];
      e.done = (i == b.size() - 1);
      e.pre5 = (i == 4);
      q.push_back(e);
    end
  endtask

  task automatic model_edge(input logic rst_v, input logic val_v, input logic [7:0] d);
    if (!rst_v) begin
      if (!cur_idle && !cur.done && sent_q.size() > 0) void'(sent_q.pop_back());
      q.delete();
      cur = '0;
      cur_idle = 1'b1;
      idle_run = GAP - 1;
      rx_pos = 0;
    end else if (val_v && exp_ready) begin
      build_frame(d);
      sent_q.push_back(d);
      cur = q.pop_front();
      cur_idle = 1'b0;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      if (!cur_idle) idle_run = 0;
      else if (idle_run < GAP - 1) idle_run++;
      cur = '0;
      cur_idle = 1'b1;
    end
    exp_ready = cur_idle && (idle_run == GAP - 1);
  endtask

  task automatic checkOutput();
    logic det;
    det = ({dhist, j} == 5'b10010);
    dhist = {dhist[2:0], j};
    if (det) det_count++;
    if (!cur_idle && cur.pre5) pre5_count++;
    check("j", 32'(j), 32'(cur.j));
    check("stuff", 32'(stuff), 32'(cur.stuff));
    check("frame_done", 32'(frame_done), 32'(cur.done));
    check("busy", 32'(busy), 32'(!cur_idle));
    check("din_ready", 32'(din_ready), 32'(exp_ready));
    check("detector", 32'(det), 32'(!cur_idle && cur.pre5));
    if (busy === 1'b1 && stuff === 1'b0) begin
      rx_pos++;
      if (rx_pos > 5) rx_word = {rx_word[6:0], j};
    end
    if (frame_done === 1'b1) begin
      if (sent_q.size() == 0) check("rx_unexpected_frame", 32'(rx_word), 32'hFFFF_FFFF);
      else check("rx_word", 32'(rx_word), 32'(sent_q.pop_front()));
      rx_pos = 0;
    end
  endtask

  task automatic tick();
    logic       rst_v, val_v;
    logic [7:0] d;
    rst_v = rst; val_v = din_valid; d = din;
    @(posedge clk);
    model_edge(rst_v, val_v, d);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [7:0] w, input logic hold);
    logic ok;
    ok = 1'b0;
    din = w;
    din_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = exp_ready;
      tick();
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    if (!hold) begin
      din_valid = 1'b0;
      din = 8'($urandom);
    end
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (!(cur_idle && exp_ready) && i < 100) begin
      tick();
      i++;
    end
    if (i >= 100) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // Called on the first frame bit; literal line and stuff patterns, MSB = first bit.
  task automatic expect_frame(input int n, input logic [15:0] jb, input logic [15:0] sb, input string name);
    for (int i = 0; i < n; i++) begin
      check({name, "_j"}, 32'(j), 32'(jb[n-1-i]));
      check({name, "_stuff"}, 32'(stuff), 32'(sb[n-1-i]));
      check({name, "_done"}, 32'(frame_done), 32'(i == n - 1));
      tick();
    end
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
    check({name, "_idle_j"}, 32'(j), 32'd0);
  endtask

  initial begin
    int zeros, rdy, gap;
    logic ok;
    rst = 1'b0; din_valid = 1'b0; din = 8'h00;
    tick();
    tick();
    check("reset_j", 32'(j), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_stuff", 32'(stuff), 32'd0);
    check("reset_done", 32'(frame_done), 32'd0);
    check("reset_ready", 32'(din_ready), 32'd1);
    rst = 1'b1;

    applyStimulus(8'hFF, 1'b0);
    expect_frame(13, 16'b1001011111111, 16'b0, "ff");
    applyStimulus(8'h90, 1'b0);
    expect_frame(14, 16'b10010100110000, 16'b00000000010000, "h90");
    applyStimulus(8'h49, 1'b0);
    expect_frame(16, 16'b1001001100110011, 16'b0000000100010001, "h49");

    // Back-to-back frames with din_valid held through the gap.
    applyStimulus(8'h09, 1'b1);
    din = 8'hA5;
    zeros = 0; rdy = 0; ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (busy === 1'b0) zeros++;
      if (din_ready === 1'b1) rdy++;
      ok = exp_ready;
      tick();
    end
    din_valid = 1'b0;
    check("b2b_gap_zeros", 32'(zeros), 32'd3);
    check("b2b_ready_cycles", 32'(rdy), 32'd1);
    check("b2b_second_start", 32'(j), 32'd1);
    wait_idle();

    // Reset while the third data bit of 8'hF0 is on the line.
    applyStimulus(8'hF0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    check("midrst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_j", 32'(j), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(din_ready), 32'd1);
    check("midrst_done", 32'(frame_done), 32'd0);
    applyStimulus(8'h3C, 1'b0);
    wait_idle();

    for (int n = 0; n < 2000; n++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        din = 8'($urandom);
        tick();
      end
      applyStimulus(8'($urandom), 1'b0);
    end
    wait_idle();
    tick();

    check("detector_count", 32'(det_count), 32'(pre5_count));
    check("rx_pending", 32'(sent_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq10010_tx.md
# seq10010_tx

Bit-serial frame transmitter that drives the serial line monitored by the 10010 Mealy detector. Each accepted parallel word goes out as the sync preamble 1,0,0,1,0 followed by its data bits, MSB first. Bit stuffing and a mandatory idle gap guarantee that a downstream 10010 detector fires exactly once per frame, on the last preamble bit. The block sits between a parallel producer (valid/ready) and the serial line `j`.

## Interface
- WIDTH, 8, payload bits per frame
- GAP, 3, minimum idle zeros between frames; values below 3 are illegal
- clk  in  1  rising-edge clock, one line bit per cycle
- rst  in  1  reset; one clock; reset is synchronous and active-low
- din  in  WIDTH  payload word
- din_valid  in  1  producer has a word
- din_ready  out  1  block accepts `din` this cycle
- j  out  1  serial line (registered)
- busy  out  1  frame in progress
- stuff  out  1  current `j` bit is a stuffed bit
- frame_done  out  1  one-cycle pulse while the last bit of a frame is on `j`

## Operation
- States:
  - IDLE: `j`=0.
  - PRE: 5 cycles, bits 1,0,0,1,0.
  - DATA: WIDTH data bits plus any stuffed bits.
  - TAIL: 0 or 1 cycle.
- History register h[3:0] holds the last 4 bits driven on `j`. It updates every cycle in every state, including idle zeros and preamble bits. Reset value is 0000.
- Handshake: a transfer occurs on the edge where din_valid=1 and din_ready=1. `din` is captured into the shift register, and the first preamble bit appears on the next cycle.
- `din_valid` is ignored when din_ready=0. `din` need not be held after the transfer.
- Stuffing in DATA:
  - If h==1001, drive `j`=1 and `stuff`=1, and do not consume a data bit.
  - Otherwise drive the next data bit MSB-first.
  - The stuff check also applies to the first data bit, so history from the preamble counts (preamble tail "10" followed by data "01…" stuffs).
- After the last data bit: if h==1001, go to TAIL and emit one stuffed 1 (`stuff`=1). Otherwise go straight to IDLE.
- `frame_done` is asserted on the last bit of the frame: either the last data bit or the TAIL bit.
- Gap counter gap_cnt:
  - Counts completed idle cycles and saturates at GAP-1.
  - Cleared when the frame ends; it is 0 in the first idle cycle.
  - din_ready = (state==IDLE) && (gap_cnt==GAP-1).
- Frame length is 5 + WIDTH + stuffed bits. Stuffed bits are never consecutive, because h becomes 0011 after a stuff.
- Reset (rst=0 at an edge):
  - Takes effect on the next cycle: state IDLE, h=0000, gap_cnt=GAP-1, j=0, busy=0, stuff=0, frame_done=0, din_ready=1.
  - Reset mid-frame drops the word in flight; no partial frame resumes.

## Timing
- Accept at edge t → `j` carries preamble bit 1 in cycle t+1, and busy=1 from t+1 through the last frame bit.
- The first idle cycle after a frame has busy=0 and `j`=0.
- Back-to-back frames with din_valid held: exactly GAP zero bits between the last frame bit and the next preamble 1.
- After reset, din_ready=1 in the first cycle with rst=1, so a frame can start immediately.
- Outputs `j`, `stuff` and `frame_done` are registered and change only at clk edges.
- din_ready is decoded from registered state only.

## Test plan
- Reset: hold rst=0 for 2 cycles. Required: j=0, busy=0, stuff=0, frame_done=0, din_ready=1. Release and send 8'hFF. Required: j = 1,0,0,1,0,1,1,1,1,1,1,1,1 (13 bits), no stuff, frame_done on bit 13.
- Send 8'h90. Required: j = 1,0,0,1,0,1,0,0,1,1,0,0,0,0. stuff=1 only on bit 10. frame_done on bit 14.
- Send 8'h49. Required: j = 1,0,0,1,0,0,1,1,0,0,1,1,0,0,1,1. stuff=1 on bits 8, 12 and 16; bit 16 is the TAIL stuff. frame_done on bit 16.
- Back-to-back 8'h09 then 8'hA5 with din_valid held, GAP=3. Required: exactly 3 zeros between frames, din_ready high only in the third idle cycle. A golden 10010 Mealy detector on `j` fires exactly once per frame, on the 5th preamble bit.
- Reset mid-frame: drive rst=0 during the 3rd data bit. Required: next cycle j=0, busy=0, din_ready=1, no frame_done. The next word transmits a clean, complete frame.
- Random soak: 2000 random words with random din_valid gaps. Required: the detector count equals the accepted-word count, and destuffed line data matches the input words in order.
